// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front end.
// Owns the fetch PC and drives a req/ready instruction-memory port.
// Presents each fetched word with its PC+4 to the IF/ID register.
// When no word is presented, the outputs carry the all-zero bubble.
//
// Handshake: imem_req stays high with imem_addr stable until the
// one-cycle imem_ready pulse. imem_rdata is valid in that same cycle.
// A presented word (valid=1) is consumed on a rising edge where the unit
// is holding a word and neither freeze nor branch_taken is high.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,  // request outstanding, result will be kept
        DISCARD = 2'd1,  // request outstanding, result will be dropped
        HOLD    = 2'd2   // presenting a word to IF/ID, no request
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0] br_tgt;
    logic [31:0] pc_plus4;

    // Branch targets are word aligned; the low two bits are forced to zero.
    assign br_tgt   = branch_address & 32'hFFFF_FFFC;
    // Modulo-2^32 increment, so the top word wraps to address zero.
    assign pc_plus4 = fetch_pc_q + 32'd4;

    // State register and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            target_q   <= 32'h0;
            instr_q    <= 32'h0;
            pc_q       <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

    // Next-state logic: fetch, redirect and consumption decisions.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (branch_taken) begin
                        // Returned word is on the wrong path; refetch at target.
                        fetch_pc_d = br_tgt;
                    end else begin
                        instr_d    = imem_rdata;
                        pc_d       = pc_plus4;
                        fetch_pc_d = pc_plus4;
                        state_d    = HOLD;
                    end
                end else if (branch_taken) begin
                    // Address must not move under an outstanding request,
                    // so park the target until the memory answers.
                    target_d = br_tgt;
                    state_d  = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_ready) begin
                    fetch_pc_d = branch_taken ? br_tgt : target_q;
                    state_d    = FETCH;
                end else if (branch_taken) begin
                    // Newest redirect wins.
                    target_d = br_tgt;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    // Redirect beats freeze: the held word is squashed.
                    fetch_pc_d = br_tgt;
                    state_d    = FETCH;
                end else if (!freeze) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Outputs: request gated by reset, bubble whenever nothing is presented.
    always_comb begin
        imem_req    = rst && (state_q != HOLD);
        imem_addr   = fetch_pc_q;
        valid       = rst && (state_q == HOLD);
        PC          = valid ? pc_q : 32'h0;
        instruction = valid ? instr_q : 32'h0;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit.
// u_dut uses RESET_PC=0 with a variable-latency memory returning word=addr.
// u_wrap uses RESET_PC=FFFF_FFFC with a zero-latency memory.
module tb_if_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic rst2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 signals ----------------
  logic        freeze;
  logic        br;
  logic [31:0] br_addr;
  logic        req1;
  logic [31:0] addr1;
  logic        rdy1;
  logic [31:0] rdata1;
  logic [31:0] pc1;
  logic [31:0] ins1;
  logic        vld1;

  // ---------------- DUT 2 signals ----------------
  logic        zero_b;
  logic [31:0] zero_w;
  logic        req2;
  logic [31:0] addr2;
  logic        rdy2;
  logic [31:0] rdata2;
  logic [31:0] pc2;
  logic [31:0] ins2;
  logic        vld2;

  // ---------------- memory model ----------------
  // Ready fires when the request has waited lat cycles; data = address.
  int lat;
  int cnt;

  assign rdy1   = req1 && (cnt == lat);
  assign rdata1 = addr1;
  assign rdy2   = req2;
  assign rdata2 = addr2;

  always @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= 0;
    else if (rdy1) cnt <= 0;
    else if (req1) cnt <= cnt + 1;
  end

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (br),
    .branch_address (br_addr),
    .imem_req       (req1),
    .imem_addr      (addr1),
    .imem_ready     (rdy1),
    .imem_rdata     (rdata1),
    .PC             (pc1),
    .instruction    (ins1),
    .valid          (vld1)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .rst            (rst2),
    .freeze         (zero_b),
    .branch_taken   (zero_b),
    .branch_address (zero_w),
    .imem_req       (req2),
    .imem_addr      (addr2),
    .imem_ready     (rdy2),
    .imem_rdata     (rdata2),
    .PC             (pc2),
    .instruction    (ins2),
    .valid          (vld2)
  );

  // ---------------- scoreboard ----------------
  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check all outputs of one DUT (1 = u_dut, 2 = u_wrap) after settling.
  task automatic expect_o(input string tag, input int which, input logic req,
                          input logic [31:0] addr, input logic vld,
                          input logic [31:0] pc, input logic [31:0] ins);
    #1;
    if (which == 1) begin
      chk({tag, ".req"},   {31'h0, req1}, {31'h0, req});
      chk({tag, ".addr"},  addr1, addr);
      chk({tag, ".valid"}, {31'h0, vld1}, {31'h0, vld});
      chk({tag, ".pc"},    pc1, pc);
      chk({tag, ".instr"}, ins1, ins);
    end else begin
      chk({tag, ".req"},   {31'h0, req2}, {31'h0, req});
      chk({tag, ".addr"},  addr2, addr);
      chk({tag, ".valid"}, {31'h0, vld2}, {31'h0, vld});
      chk({tag, ".pc"},    pc2, pc);
      chk({tag, ".instr"}, ins2, ins);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    rst2    = 1'b0;
    freeze  = 1'b0;
    br      = 1'b0;
    br_addr = 32'h0;
    zero_b  = 1'b0;
    zero_w  = 32'h0;
    lat     = 0;

    // Reset state
    step();
    step();
    expect_o("reset", 1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    expect_o("release", 1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Straight-line fetch, zero-latency memory
    step(); expect_o("sl_h0", 1, 1'b0, 32'h4, 1'b1, 32'h4, 32'h0);
    step(); expect_o("sl_f1", 1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    step(); expect_o("sl_h1", 1, 1'b0, 32'h8, 1'b1, 32'h8, 32'h4);

    // Freeze hold for three cycles
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_o("frz", 1, 1'b0, 32'h8, 1'b1, 32'h8, 32'h4);
    end
    freeze = 1'b0;
    step(); expect_o("frz_f", 1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    step(); expect_o("frz_h", 1, 1'b0, 32'hC, 1'b1, 32'hC, 32'h8);
    step(); expect_o("sl_f3", 1, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
    step(); expect_o("sl_h3", 1, 1'b0, 32'h10, 1'b1, 32'h10, 32'hC);

    // Branch in HOLD under freeze, misaligned target
    freeze  = 1'b1;
    br      = 1'b1;
    br_addr = 32'h103;
    step();
    br     = 1'b0;
    freeze = 1'b0;
    expect_o("bh_f", 1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    step(); expect_o("bh_h", 1, 1'b0, 32'h104, 1'b1, 32'h104, 32'h100);

    // Branch during outstanding request, 3-cycle memory
    lat = 3;
    step();
    br      = 1'b1;
    br_addr = 32'h200;
    expect_o("bo_w0", 1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
    step();
    br = 1'b0;
    expect_o("bo_w1", 1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
    step(); expect_o("bo_w2", 1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
    step(); expect_o("bo_rdy", 1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
    step(); expect_o("bo_tgt", 1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); expect_o("bo_wait", 1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
    end
    step(); expect_o("bo_h", 1, 1'b0, 32'h204, 1'b1, 32'h204, 32'h200);

    // Double branch while discarding: newest target wins
    step();
    br      = 1'b1;
    br_addr = 32'h200;
    expect_o("db_w0", 1, 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
    step();
    br_addr = 32'h300;
    expect_o("db_w1", 1, 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
    step();
    br = 1'b0;
    expect_o("db_w2", 1, 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
    step(); expect_o("db_rdy", 1, 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
    step();
    lat = 0;
    expect_o("db_tgt", 1, 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
    step(); expect_o("db_h", 1, 1'b0, 32'h304, 1'b1, 32'h304, 32'h300);

    // Branch in the same cycle as ready in FETCH: data dropped
    step();
    br      = 1'b1;
    br_addr = 32'h40;
    expect_o("fr_f", 1, 1'b1, 32'h304, 1'b0, 32'h0, 32'h0);
    step();
    br = 1'b0;
    expect_o("fr_tgt", 1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    step(); expect_o("fr_h", 1, 1'b0, 32'h44, 1'b1, 32'h44, 32'h40);

    // Wrap-around and asynchronous reset on the second instance
    rst2 = 1'b1;
    expect_o("wr_rel", 2, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    step(); expect_o("wr_h", 2, 1'b0, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFC);
    step(); expect_o("wr_f", 2, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(); expect_o("wr_h2", 2, 1'b0, 32'h4, 1'b1, 32'h4, 32'h0);
    step(); expect_o("wr_f2", 2, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    rst2 = 1'b0;
    expect_o("ar_mid", 2, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    step();
    rst2 = 1'b1;
    expect_o("ar_rel", 2, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    step(); expect_o("ar_h", 2, 1'b0, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFC);

    // Async reset while u_wrap presents a word: bubble immediately
    rst2 = 1'b0;
    expect_o("ar_hold", 2, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
